// File: rtl/uart_fifo_write_arbiter.sv
// Write-port arbiter for the 16-byte UART FIFO: round-robin between the RX
// byte stream and the CPU store path, with occupancy tracking and RX drop accounting.
module uart_fifo_write_arbiter #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          UART_CLK,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          cpu_valid,
  input  logic [7:0]    cpu_data,
  output logic          cpu_ready,
  input  logic          rd_pop,
  input  logic          ovf_clr,
  output logic          fifo_write_req,
  output logic [7:0]    fifo_write_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {GR_RX = 1'b0, GR_CPU = 1'b1} grant_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  grant_e        last_grant_q, last_grant_d;
  logic          rx_pend_q, rx_pend_d;
  logic [7:0]    rx_hold_q, rx_hold_d;
  logic          fifo_write_req_q, fifo_write_req_d;
  logic [7:0]    fifo_write_data_q, fifo_write_data_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic room, grant_rx, grant_cpu, grant, pop_eff, drop;

  always_comb begin
    // A same-cycle rd_pop does not open a slot: room uses the committed count only.
    room      = (count_q != DEPTH_C);
    grant_rx  = !reset && room && rx_pend_q && (!cpu_valid || last_grant_q == GR_CPU);
    grant_cpu = !reset && room && cpu_valid && (!rx_pend_q || last_grant_q == GR_RX);
    grant     = grant_rx || grant_cpu;
    pop_eff   = rd_pop && (count_q != '0);
    drop      = rx_valid && rx_pend_q && !grant_rx;
    cpu_ready = grant_cpu;

    last_grant_d      = last_grant_q;
    rx_pend_d         = rx_pend_q;
    rx_hold_d         = rx_hold_q;
    fifo_write_req_d  = grant;
    fifo_write_data_d = fifo_write_data_q;
    count_d           = count_q;
    overflow_d        = overflow_q;
    drop_cnt_d        = drop_cnt_q;

    if (grant_rx) begin
      last_grant_d      = GR_RX;
      fifo_write_data_d = rx_hold_q;
      rx_pend_d         = 1'b0;
    end else if (grant_cpu) begin
      last_grant_d      = GR_CPU;
      fifo_write_data_d = cpu_data;
    end

    // The hold register accepts a new byte only when its slot is free or draining now.
    if (rx_valid && !drop) begin
      rx_hold_d = rx_data;
      rx_pend_d = 1'b1;
    end

    if (grant && !pop_eff)      count_d = count_q + CW'(1);
    else if (!grant && pop_eff) count_d = count_q - CW'(1);

    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc8(drop_cnt_q);
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge UART_CLK) begin
    if (reset) begin
      last_grant_q      <= GR_CPU;
      rx_pend_q         <= 1'b0;
      fifo_write_req_q  <= 1'b0;
      fifo_write_data_q <= 8'h00;
      count_q           <= '0;
      full_q            <= 1'b0;
      empty_q           <= 1'b1;
      overflow_q        <= 1'b0;
      drop_cnt_q        <= 8'h00;
    end else begin
      last_grant_q      <= last_grant_d;
      rx_pend_q         <= rx_pend_d;
      fifo_write_req_q  <= fifo_write_req_d;
      fifo_write_data_q <= fifo_write_data_d;
      count_q           <= count_d;
      full_q            <= full_d;
      empty_q           <= empty_d;
      overflow_q        <= overflow_d;
      drop_cnt_q        <= drop_cnt_d;
    end
  end

  always_ff @(posedge UART_CLK) begin
    rx_hold_q <= rx_hold_d;
  end

  assign fifo_write_req  = fifo_write_req_q;
  assign fifo_write_data = fifo_write_data_q;
  assign count           = count_q;
  assign full            = full_q;
  assign empty           = empty_q;
  assign overflow        = overflow_q;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_uart_fifo_write_arbiter.sv
// Scoreboard bench for uart_fifo_write_arbiter: directed scenarios followed by
// randomized traffic, checked against a queue-based model of the FIFO and RX slot.
module tb_uart_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cpu_valid = 1'b0;
  logic [7:0] cpu_data = 8'h00;
  logic       cpu_ready;
  logic       rd_pop = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       fifo_write_req;
  logic [7:0] fifo_write_data;
  logic [4:0] count;
  logic       full, empty, overflow;
  logic [7:0] drop_cnt;

  uart_fifo_write_arbiter #(.DEPTH(16), .CW(5)) dut (
    .UART_CLK(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
    .rd_pop(rd_pop), .ovf_clr(ovf_clr),
    .fifo_write_req(fifo_write_req), .fifo_write_data(fifo_write_data),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cnt;
    bit         fl;
    bit         em;
    bit         ovf;
    int         drp;
    bit         wreq;
    logic [7:0] wdat;
  } st_t;

  st_t        st_q[$];
  bit         rdy_q[$];
  logic [7:0] wr_q[$];

  // Reference model: FIFO contents, the one-byte RX slot, and whose turn it is.
  logic [7:0] fifo_m[$];
  logic [7:0] rxp_m[$];
  bit         last_cpu_m = 1'b1;
  bit         ovf_m = 1'b0;
  int         drop_m = 0;
  bit         wrreq_m = 1'b0;
  logic [7:0] wrdata_m = 8'h00;
  bit         m_valid = 1'b0;
  bit         cpu_granted = 1'b0;

  int  errors = 0;
  int  checks = 0;
  bit  done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic cycle(input bit rst_i, input bit rv, input logic [7:0] rd,
                       input bit cv, input logic [7:0] cd, input bit pop, input bit clr);
    st_t s;
    bit  room, rxc, g_rx, g_cpu, drop;
    @(posedge clk);
    #1;
    if (m_valid) begin
      s.cnt = fifo_m.size(); s.fl = (fifo_m.size() == 16); s.em = (fifo_m.size() == 0);
      s.ovf = ovf_m; s.drp = drop_m; s.wreq = wrreq_m; s.wdat = wrdata_m;
      st_q.push_back(s);
    end
    reset = rst_i; rx_valid = rv; rx_data = rd; cpu_valid = cv; cpu_data = cd;
    rd_pop = pop; ovf_clr = clr;
    if (rst_i) begin
      fifo_m.delete(); rxp_m.delete();
      last_cpu_m = 1'b1; ovf_m = 1'b0; drop_m = 0; wrreq_m = 1'b0; wrdata_m = 8'h00;
      m_valid = 1'b1; cpu_granted = 1'b0;
    end else begin
      room = fifo_m.size() < 16;
      rxc  = rxp_m.size() != 0;
      if (room && rxc && cv) begin
        g_rx = last_cpu_m; g_cpu = !last_cpu_m;
      end else begin
        g_rx = room && rxc; g_cpu = room && cv && !rxc;
      end
      drop = rv && rxc && !g_rx;
      if (pop && fifo_m.size() > 0) void'(fifo_m.pop_front());
      wrreq_m = g_rx || g_cpu;
      if (g_rx)  begin wrdata_m = rxp_m.pop_front(); last_cpu_m = 1'b0; end
      if (g_cpu) begin wrdata_m = cd; last_cpu_m = 1'b1; end
      if (wrreq_m) begin fifo_m.push_back(wrdata_m); wr_q.push_back(wrdata_m); end
      if (rv && !drop) rxp_m.push_back(rd);
      if (drop) begin
        ovf_m = 1'b1;
        if (drop_m < 255) drop_m++;
      end else if (clr) begin
        ovf_m = 1'b0;
      end
      cpu_granted = g_cpu;
    end
    rdy_q.push_back(cpu_granted);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, 8'h00, 0, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    st_t e;
    logic [7:0] w;
    while (!done) begin
      @(negedge clk);
      if (done) break;
      if (rdy_q.size() > 0) chk("cpu_ready", 32'(cpu_ready), 32'(rdy_q.pop_front()));
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("count", 32'(count), 32'(e.cnt));
        chk("full", 32'(full), 32'(e.fl));
        chk("empty", 32'(empty), 32'(e.em));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(e.drp));
        chk("write_req", 32'(fifo_write_req), 32'(e.wreq));
        chk("write_data_reg", 32'(fifo_write_data), 32'(e.wdat));
        if (fifo_write_req === 1'b1) begin
          if (wr_q.size() == 0) begin
            chk("write_unexpected", 32'(fifo_write_data), 32'hFFFF_FFFF);
          end else begin
            w = wr_q.pop_front();
            chk("write_byte", 32'(fifo_write_data), 32'(w));
          end
        end
      end
    end
  end

  initial begin
    bit         cpu_req;
    logic [7:0] cpu_byte;
    cycle(1, 0, 8'h00, 0, 8'h00, 0, 0);
    cycle(1, 0, 8'h00, 0, 8'h00, 0, 0);

    // RX only, alternate cycles
    cycle(0, 1, 8'h41, 0, 8'h00, 0, 0); idle(1);
    cycle(0, 1, 8'h42, 0, 8'h00, 0, 0); idle(1);
    cycle(0, 1, 8'h43, 0, 8'h00, 0, 0); idle(3);

    // Contention: RX wins the first tie after reset, CPU goes next
    cycle(1, 0, 8'h00, 0, 8'h00, 0, 0);
    cycle(0, 1, 8'h20, 0, 8'h00, 0, 0);
    cycle(0, 0, 8'h00, 1, 8'h10, 0, 0);
    cycle(0, 0, 8'h00, 1, 8'h10, 0, 0);
    idle(2);

    // Fill to full, stall, pop one, refill
    cycle(1, 0, 8'h00, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 8'h00, 1, 8'(8'h80 + i), 0, 0);
    cycle(0, 0, 8'h00, 1, 8'hC0, 0, 0);
    cycle(0, 0, 8'h00, 1, 8'hC0, 0, 0);
    cycle(0, 0, 8'h00, 1, 8'hC0, 1, 0);
    cycle(0, 0, 8'h00, 1, 8'hC0, 0, 0);
    idle(2);

    // RX drop while full, then drain the held byte
    cycle(0, 1, 8'hAA, 0, 8'h00, 0, 0);
    cycle(0, 1, 8'hBB, 0, 8'h00, 0, 0);
    idle(1);
    cycle(0, 0, 8'h00, 0, 8'h00, 1, 0);
    idle(3);

    // Grant and pop together at count 7; clear racing a drop
    cycle(1, 0, 8'h00, 0, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 8'h00, 1, 8'(i), 0, 0);
    cycle(0, 0, 8'h00, 1, 8'h07, 1, 0);
    cycle(0, 1, 8'h55, 0, 8'h00, 0, 0);
    idle(1);
    cycle(0, 1, 8'h66, 0, 8'h00, 0, 0);
    cycle(0, 1, 8'h77, 1, 8'h99, 0, 1);
    idle(2);
    cycle(0, 0, 8'h00, 0, 8'h00, 0, 1);
    idle(2);

    // Reset with a pending RX byte and count 5
    cycle(1, 0, 8'h00, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1, 8'(8'h30 + i), 0, 0);
    cycle(0, 1, 8'h99, 0, 8'h00, 0, 0);
    cycle(1, 0, 8'h00, 0, 8'h00, 0, 0);
    idle(3);

    // Randomized traffic with a well-behaved CPU requester
    cpu_req = 1'b0; cpu_byte = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if (!cpu_req && $urandom_range(9) < 3) begin
        cpu_req = 1'b1; cpu_byte = 8'($urandom);
      end
      cycle(($urandom_range(199) == 0), ($urandom_range(9) < 4), 8'($urandom),
            cpu_req, cpu_byte, ($urandom_range(9) < 3), ($urandom_range(19) == 0));
      if (cpu_granted) cpu_req = 1'b0;
    end
    idle(3);

    @(negedge clk);
    #1;
    done = 1'b1;
    chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
